// File: rtl/spart_tx_sched.sv
// spart_tx_sched: round-robin arbiter that shares one SPART transmitter among
// NUM_REQ byte sources. Each granted byte becomes a single-cycle write to the
// transmit register. The block then waits for tbr to fall and rise again
// before it makes the next grant. An optional packet lock keeps the grant with
// one source until that source sends a byte marked req_last.
module spart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   tbr,
  output logic [1:0]             tx_ioaddr,
  output logic                   tx_iorw,
  output logic [7:0]             tx_data,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                lock_q, lock_d;
  logic [ID_W-1:0]     lock_id_q, lock_id_d;
  logic [1:0]          tx_ioaddr_q, tx_ioaddr_d;
  logic                tx_iorw_q, tx_iorw_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  eligible_s;
  logic [NUM_REQ-1:0]  lock_mask_s;
  logic                win_found_s;
  logic [ID_W-1:0]     win_idx_s;
  logic [ID_W:0]       cand_s;
  logic                take_s;
  logic                grant_s;
  logic [7:0]          win_data_s;
  logic                win_last_s;
  logic [ID_W-1:0]     next_ptr_s;

  // While a packet is locked only the lock owner may compete.
  always_comb begin
    lock_mask_s = ONE_HOT_0 << lock_id_q;
    eligible_s  = lock_q ? (req_valid & lock_mask_s) : req_valid;
  end

  // Find the first eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    take_s      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      cand_s      = (cand_s >= (ID_W+1)'(NUM_REQ)) ? (cand_s - (ID_W+1)'(NUM_REQ)) : cand_s;
      take_s      = !win_found_s && eligible_s[cand_s[ID_W-1:0]];
      win_idx_s   = take_s ? cand_s[ID_W-1:0] : win_idx_s;
      win_found_s = win_found_s | take_s;
    end
  end

  // A grant needs the IDLE state, an idle transmitter and an eligible requester.
  always_comb begin
    grant_s    = (state_q == ST_IDLE) && win_found_s && tbr;
    win_data_s = req_data[int'(win_idx_s)*8 +: 8];
    win_last_s = req_last[win_idx_s];
    next_ptr_s = (win_idx_s == ID_W'(NUM_REQ-1)) ? '0 : (win_idx_s + ID_W'(1));
    req_ready  = grant_s ? (ONE_HOT_0 << win_idx_s) : '0;
  end

  // Next-state logic: one strobe cycle, then follow tbr low and back high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = grant_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW:  state_d = tbr ? ST_WAIT_LOW : ST_WAIT_DONE;
      ST_WAIT_DONE: state_d = tbr ? ST_IDLE : ST_WAIT_DONE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the arbitration state. The
  // strobe is set only on a grant, so it falls back to 01/1 in the ISSUE cycle.
  always_comb begin
    tx_ioaddr_d = 2'b01;
    tx_iorw_d   = 1'b1;
    tx_data_d   = tx_data_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    if (grant_s) begin
      tx_ioaddr_d = 2'b00;
      tx_iorw_d   = 1'b0;
      tx_data_d   = win_data_s;
      grant_id_d  = win_idx_s;
      rr_ptr_d    = next_ptr_s;
      lock_d      = ~win_last_s;
      lock_id_d   = win_idx_s;
    end else begin
      tx_data_d   = tx_data_q;
      grant_id_d  = grant_id_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers. An asynchronous reset drops the strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      tx_ioaddr_q <= 2'b01;
      tx_iorw_q   <= 1'b1;
      tx_data_q   <= 8'h00;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      tx_ioaddr_q <= tx_ioaddr_d;
      tx_iorw_q   <= tx_iorw_d;
      tx_data_q   <= tx_data_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_ioaddr = tx_ioaddr_q;
  assign tx_iorw   = tx_iorw_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spart_tx_sched.sv
// Bench for spart_tx_sched: per-source byte queues, a simple transmitter
// model that drives tbr, and a transaction-level arbitration model.
module tb_spart_tx_sched;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tbr;
  logic [1:0]      tx_ioaddr;
  logic            tx_iorw;
  logic [7:0]      tx_data;
  logic [IW-1:0]   grant_id;
  logic            busy;

  always #5 clk = ~clk;

  spart_tx_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tbr(tbr),
    .tx_ioaddr(tx_ioaddr), .tx_iorw(tx_iorw), .tx_data(tx_data),
    .grant_id(grant_id), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state
  logic [8:0] q [N][$];            // {last, data} per source
  int   m_ptr = 0;
  bit   m_lock = 1'b0;
  int   m_lock_id = 0;
  logic [7:0] data_exp = 8'h00;
  int   id_exp = 0;
  int   last_grant = -100;
  int   idle_from = 0;
  int   busy_cnt = 0;
  bit   load_pending = 1'b0;
  int   tx_time_nxt = 1;
  int   force_t = 0;
  bit   gaps_on = 1'b0;
  bit   rand_hold = 1'b0;
  int   n_grants = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int q_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += q[i].size();
    return t;
  endfunction

  task automatic check_reset_vals();
    check_eq("rst_ioaddr",   tx_ioaddr, 2'b01);
    check_eq("rst_iorw",     tx_iorw, 1'b1);
    check_eq("rst_data",     tx_data, 8'h00);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_busy",     busy, 1'b0);
    check_eq("rst_ready",    req_ready, 0);
  endtask

  // One clock: drive at the falling edge, check 1 time unit later.
  task automatic step(input bit hold);
    logic [N-1:0] pv, elig, exp_ready;
    logic [8:0]   ent;
    int           w;
    bit           strobe_exp;
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    if (load_pending) begin busy_cnt = tx_time_nxt; load_pending = 1'b0; end
    tbr = (busy_cnt == 0) && !(hold && cyc >= idle_from);
    if (busy_cnt > 0) busy_cnt--;
    pv = '0;
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = 8'($urandom);
      req_last[i]        = 1'($urandom);
      if (q[i].size() > 0 && !(gaps_on && $urandom_range(0, 3) == 0)) begin
        pv[i]              = 1'b1;
        req_data[8*i +: 8] = q[i][0][7:0];
        req_last[i]        = q[i][0][8];
      end
    end
    req_valid = pv;
    #1;
    elig      = m_lock ? (pv & (4'b0001 << m_lock_id)) : pv;
    exp_ready = '0;
    w         = -1;
    if (cyc >= idle_from && tbr && elig != '0) begin
      w = pick(elig, m_ptr);
      exp_ready[w] = 1'b1;
    end
    strobe_exp = (cyc == last_grant + 1);
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("tx_ioaddr", tx_ioaddr, strobe_exp ? 2'b00 : 2'b01);
    check_eq("tx_iorw",   tx_iorw, strobe_exp ? 1'b0 : 1'b1);
    check_eq("tx_data",   tx_data, data_exp);
    check_eq("grant_id",  grant_id, id_exp);
    check_eq("busy",      busy, (cyc > last_grant) && (cyc < idle_from));
    if (tx_ioaddr == 2'b00 && tx_iorw == 1'b0) load_pending = 1'b1;
    if (w >= 0) begin
      ent         = q[w].pop_front();
      data_exp    = ent[7:0];
      id_exp      = w;
      m_ptr       = (w + 1) % N;
      m_lock      = !ent[8];
      m_lock_id   = w;
      tx_time_nxt = (force_t > 0) ? force_t : $urandom_range(1, 6);
      last_grant  = cyc;
      idle_from   = cyc + tx_time_nxt + 3;
      n_grants++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_total() != 0 || cyc < idle_from) && n < budget) begin
      step(rand_hold && ($urandom_range(0, 7) == 0));
      n++;
    end
    check_eq("drain_left", q_total(), 0);
  endtask

  initial begin
    int g0, n, len;
    rst_n = 1'b0; tbr = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();

    // Idle after reset: nothing granted, strobe inactive
    repeat (8) step(1'b0);

    // Single byte from source 2
    q[2].push_back({1'b1, 8'hA5});
    drain(200);

    // All sources continuously valid
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'h40 + 8'(r*N + i))});
    drain(400);

    // Locked three-byte packet from source 1 with source 0 competing
    q[1].push_back({1'b0, 8'h11});
    q[1].push_back({1'b0, 8'h22});
    q[1].push_back({1'b1, 8'h33});
    q[0].push_back({1'b1, 8'h77});
    drain(300);

    // tbr held low while source 0 waits, then released
    q[0].push_back({1'b1, 8'h5A});
    repeat (6) step(1'b1);
    drain(200);

    // Reset while waiting for tbr to return high
    force_t = 5;
    g0 = n_grants;
    for (int b = 0; b < 3; b++) q[3].push_back({1'b1, 8'(8'hC0 + 8'(b))});
    n = 0;
    while (!(n_grants > g0 && cyc == last_grant + 3) && n < 60) begin
      step(1'b0);
      n++;
    end
    check_eq("reach_wait_done", (n_grants > g0) && (cyc == last_grant + 3), 1);
    @(negedge clk);
    rst_n = 1'b0;
    cyc++;
    #1;
    check_reset_vals();
    m_ptr = 0; m_lock = 1'b0; m_lock_id = 0;
    data_exp = 8'h00; id_exp = 0;
    last_grant = -100; idle_from = cyc + 1;
    force_t = 0;
    drain(300);

    // Randomised rounds with valid gaps and tbr holds
    gaps_on = 1'b1;
    rand_hold = 1'b1;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) begin
        len = $urandom_range(0, 4);
        for (int b = 0; b < len; b++)
          q[i].push_back({(b == len - 1) ? 1'b1 : 1'($urandom), 8'($urandom)});
      end
      drain(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
